// File: rtl/equiv_miter_driver_pkg.sv
// Shared types and helpers for the equivalence miter driver.
package equiv_miter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE_S
   } miter_state_e;

   // Deepest register latency the drain counter has to cover.
   localparam int unsigned MAX_LAT = 8;

   // Number of input vectors enumerated for a stimulus width.
   function automatic int unsigned vec_count(input int unsigned in_w);
      return 32'd1 << in_w;
   endfunction

endpackage

// File: rtl/equiv_miter_driver_if.sv
// Stimulus/response bundle between the miter driver and the harness holding circuits A and B.
// MISMATCH_CNT is present only when MITER_CEX_COUNT_EN is defined.
interface equiv_miter_driver_if #(
   parameter int unsigned IN_W  = 2,
   parameter int unsigned OUT_W = 1
);
   logic             START;
   logic [IN_W-1:0]  STIM;
   logic [OUT_W-1:0] OUT_A;
   logic [OUT_W-1:0] OUT_B;
   logic             BUSY;
   logic             DONE;
   logic             SAT;
   logic [IN_W-1:0]  CEX;
`ifdef MITER_CEX_COUNT_EN
   logic [IN_W:0]    MISMATCH_CNT;

   modport master (
      input  START, OUT_A, OUT_B,
      output STIM, BUSY, DONE, SAT, CEX, MISMATCH_CNT
   );
   modport slave (
      output START, OUT_A, OUT_B,
      input  STIM, BUSY, DONE, SAT, CEX, MISMATCH_CNT
   );
`else
   modport master (
      input  START, OUT_A, OUT_B,
      output STIM, BUSY, DONE, SAT, CEX
   );
   modport slave (
      output START, OUT_A, OUT_B,
      input  STIM, BUSY, DONE, SAT, CEX
   );
`endif
endinterface

// File: rtl/equiv_miter_driver_delay_line.sv
// Depth-deep shift register carrying {valid, vector} alongside the circuits' pipeline.
// Depth 0 is a pure pass-through.
module miter_delay_line #(
   parameter int unsigned Depth = 0,
   parameter int unsigned Width = 3
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             clr_i,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   if (Depth == 0) begin : g_pass
      logic unused_pass;
      assign unused_pass = ^{CLK, RST_N, clr_i};
      assign q_o = d_i;
   end else begin : g_shift
      logic [Width-1:0] line_q [Depth];

      // Shift one slot per cycle; clear flushes stale vectors from an abandoned run.
      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            for (int i = 0; i < int'(Depth); i++) line_q[i] <= '0;
         end else if (clr_i) begin
            for (int i = 0; i < int'(Depth); i++) line_q[i] <= '0;
         end else begin
            line_q[0] <= d_i;
            for (int i = 1; i < int'(Depth); i++) line_q[i] <= line_q[i-1];
         end
      end

      assign q_o = line_q[Depth-1];
   end

endmodule

// File: rtl/equiv_miter_driver.sv
// Exhaustive equivalence miter driver: enumerates all 2^IN_W vectors into circuits A and B,
// compares their outputs LAT cycles later and reports SAT plus a counterexample.
// Optional MITER_CEX_COUNT_EN: run the full enumeration and count mismatching vectors.
module equiv_miter_driver
   import equiv_miter_pkg::*;
#(
   parameter int unsigned IN_W  = 2,
   parameter int unsigned OUT_W = 1,
   parameter int unsigned LAT   = 0
) (
   input logic                  CLK,
   input logic                  RST_N,
   equiv_miter_driver_if.master bus
);

   localparam int unsigned N      = vec_count(IN_W);
   localparam int unsigned CntW   = IN_W + 1;
   localparam int unsigned DrainW = $clog2(MAX_LAT + 1);
`ifdef MITER_CEX_COUNT_EN
   localparam bit EarlyStop = 1'b0;
`else
   localparam bit EarlyStop = 1'b1;
`endif

   miter_state_e      state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [DrainW-1:0] drain_q, drain_d;
   logic              sat_q, sat_d;
   logic [IN_W-1:0]   cex_q, cex_d;
   logic              start_acc, run_last, drain_last, cmp_valid, mismatch;
   logic [IN_W:0]     dl_in, dl_out;

   assign start_acc  = bus.START && (state_q == IDLE || state_q == DONE_S);
   assign cnt_inc    = cnt_q + 1'b1;
   // Extra counter bit lets the terminal count N be seen without wrapping to 0.
   assign run_last   = (cnt_inc == CntW'(N));
   assign drain_last = (drain_q == DrainW'(LAT - 1));

   assign dl_in = {state_q == RUN, bus.STIM};

   miter_delay_line #(
      .Depth(LAT),
      .Width(IN_W + 1)
   ) u_delay_line (
      .CLK  (CLK),
      .RST_N(RST_N),
      .clr_i(start_acc),
      .d_i  (dl_in),
      .q_o  (dl_out)
   );

   // Busy gating keeps stale delay-line contents from touching a finished result.
   assign cmp_valid = dl_out[IN_W] && (state_q == RUN || state_q == DRAIN);
   assign mismatch  = cmp_valid && (|(bus.OUT_A ^ bus.OUT_B));

   // State register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.START) state_d = RUN;
         end
         RUN: begin
            if (mismatch && EarlyStop) state_d = DONE_S;
            else if (run_last)         state_d = (LAT > 0) ? DRAIN : DONE_S;
         end
         DRAIN: begin
            if ((mismatch && EarlyStop) || drain_last) state_d = DONE_S;
         end
         DONE_S: begin
            if (bus.START) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from state and vector counter.
   always_comb begin
      bus.BUSY = (state_q == RUN) || (state_q == DRAIN);
      bus.DONE = (state_q == DONE_S);
      bus.STIM = '0;
      if (state_q == RUN) bus.STIM = cnt_q[IN_W-1:0];
   end

   // Counters and result capture; first mismatch wins the counterexample slot.
   always_comb begin
      cnt_d   = cnt_q;
      drain_d = drain_q;
      sat_d   = sat_q;
      cex_d   = cex_q;
      if (start_acc) begin
         cnt_d   = '0;
         drain_d = '0;
         sat_d   = 1'b0;
         cex_d   = '0;
      end else begin
         if (state_q == RUN)   cnt_d   = cnt_inc;
         if (state_q == DRAIN) drain_d = drain_q + 1'b1;
         if (mismatch && !sat_q) begin
            sat_d = 1'b1;
            cex_d = dl_out[IN_W-1:0];
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q   <= '0;
         drain_q <= '0;
         sat_q   <= 1'b0;
         cex_q   <= '0;
      end else begin
         cnt_q   <= cnt_d;
         drain_q <= drain_d;
         sat_q   <= sat_d;
         cex_q   <= cex_d;
      end
   end

   assign bus.CEX = cex_q;

`ifdef MITER_CEX_COUNT_EN
   logic [IN_W:0] mm_cnt_q, mm_cnt_d;

   // Saturating count of mismatching vectors, restarted by each accepted START.
   always_comb begin
      mm_cnt_d = mm_cnt_q;
      if (start_acc)                         mm_cnt_d = '0;
      else if (mismatch && (mm_cnt_q != '1)) mm_cnt_d = mm_cnt_q + 1'b1;
   end

   // Mismatch counter register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) mm_cnt_q <= '0;
      else        mm_cnt_q <= mm_cnt_d;
   end

   assign bus.MISMATCH_CNT = mm_cnt_q;
   assign bus.SAT          = (mm_cnt_q != '0);
`else
   assign bus.SAT = sat_q;
`endif

endmodule
